// File: rtl/sdi_localdata_checker_pkg.sv
// Shared SDI local-data link definitions: frame states, word indices and defaults.
// Also meant for the generator side of the link.
package sdi_localdata_checker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StRecv = 2'd2,
        StDone = 2'd3
    } state_t;

    localparam int unsigned WORD_X              = 0;
    localparam int unsigned WORD_Y              = 1;
    localparam int unsigned ERR_W_DEFAULT       = 16;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 4096;

    // Expected count word for index idx of a ramp starting at base; wraps mod 2^32.
    function automatic logic [31:0] ramp_word(input logic [31:0] base, input logic [7:0] idx);
        return base + {24'd0, idx};
    endfunction

endpackage

// File: rtl/sdi_localdata_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sdi_localdata_checker_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sdi_localdata_checker.sv
// Receive-side checker for the per-trigger SDI local-data burst: captures BPM X/Y,
// verifies the count ramp and burst length, and keeps saturating error statistics.
module sdi_localdata_checker
    import sdi_localdata_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int unsigned ERR_W       = ERR_W_DEFAULT
) (
    input  logic             sdi_clk,
    input  logic             Reset_n,
    input  logic             Trigger,
    input  logic [7:0]       ExpWords,
    input  logic             RxDataValid,
    input  logic [31:0]      RxCountData,
    input  logic [31:0]      RxBpmPosData,
    input  logic             ClrStatus,
    output logic [31:0]      PosX,
    output logic [31:0]      PosY,
    output logic             PosValid,
    output logic [31:0]      FrameCount,
    output logic [ERR_W-1:0] SeqErrCount,
    output logic [ERR_W-1:0] LenErrCount,
    output logic [ERR_W-1:0] TimeoutCount,
    output logic             ErrSticky,
    output logic             Busy
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [7:0]          idx;
    logic [31:0]         base;
    logic [31:0]         xcap;
    logic [31:0]         ycap;
    logic                seq_flag;

    logic stray, abort, timeout, frame_end;
    logic seq_inc, len_bad, len_inc, err_any;

    always_comb begin
        stray     = 1'b0;
        abort     = 1'b0;
        timeout   = 1'b0;
        frame_end = 1'b0;
        case (state)
            StIdle:  stray = RxDataValid;
            StWait:  timeout = !Trigger && !RxDataValid && (timer == TIMER_LAST);
            StRecv: begin
                abort     = Trigger;
                frame_end = !Trigger && !RxDataValid;
            end
            default: ;
        endcase
    end

    // Frame-end accounting is done on the edge into DONE so it is visible during DONE.
    assign seq_inc = frame_end && seq_flag;
    assign len_bad = frame_end && (ExpWords != 8'd0) && (idx != ExpWords);
    assign len_inc = stray || abort || len_bad;
    assign err_any = len_inc || seq_inc || timeout;
    assign Busy    = (state != StIdle);

    always_ff @(posedge sdi_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= StIdle;
            timer      <= '0;
            idx        <= '0;
            base       <= '0;
            xcap       <= '0;
            ycap       <= '0;
            seq_flag   <= 1'b0;
            PosX       <= '0;
            PosY       <= '0;
            PosValid   <= 1'b0;
            FrameCount <= '0;
            ErrSticky  <= 1'b0;
        end else begin
            PosValid <= 1'b0;

            if (ClrStatus) begin
                FrameCount <= '0;
            end else if (frame_end) begin
                FrameCount <= FrameCount + 32'd1;
            end

            if (ClrStatus) begin
                ErrSticky <= 1'b0;
            end else if (err_any) begin
                ErrSticky <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (Trigger) begin
                        state <= StWait;
                        timer <= '0;
                    end
                end
                StWait: begin
                    if (Trigger) begin
                        timer <= '0;
                    end else if (RxDataValid) begin
                        state    <= StRecv;
                        base     <= RxCountData;
                        xcap     <= RxBpmPosData;
                        idx      <= 8'(WORD_X) + 8'd1;
                        seq_flag <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state <= StIdle;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StRecv: begin
                    if (Trigger) begin
                        // Abort: the coincident word, if any, is dropped.
                        state <= StWait;
                        timer <= '0;
                    end else if (RxDataValid) begin
                        if (RxCountData != ramp_word(base, idx)) begin
                            seq_flag <= 1'b1;
                        end
                        if (idx == 8'(WORD_Y)) begin
                            ycap <= RxBpmPosData;
                        end
                        if (idx != 8'hFF) begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        state <= StDone;
                        if (idx >= 8'd2) begin
                            PosX     <= xcap;
                            PosY     <= ycap;
                            PosValid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= Trigger ? StWait : StIdle;
                    timer <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    sdi_localdata_checker_sat_counter #(.WIDTH(ERR_W)) u_seq_cnt (
        .clk   (sdi_clk),
        .rst_n (Reset_n),
        .inc   (seq_inc),
        .clr   (ClrStatus),
        .count (SeqErrCount)
    );

    sdi_localdata_checker_sat_counter #(.WIDTH(ERR_W)) u_len_cnt (
        .clk   (sdi_clk),
        .rst_n (Reset_n),
        .inc   (len_inc),
        .clr   (ClrStatus),
        .count (LenErrCount)
    );

    sdi_localdata_checker_sat_counter #(.WIDTH(ERR_W)) u_to_cnt (
        .clk   (sdi_clk),
        .rst_n (Reset_n),
        .inc   (timeout),
        .clr   (ClrStatus),
        .count (TimeoutCount)
    );

endmodule
